// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master data-memory arbiter.
//   mem_req_t : one master's request payload (address, byte enables, data, lock)
//   M_FETCH   : index of the instruction-fetch / loader master (m0)
//   M_DATA    : index of the CPU load/store master (m1)
//   is_read() : a request with no byte-write enables is a read
package mem_bus_pkg;

    localparam int MEM_XLEN  = 32;
    localparam int MEM_BYTES = MEM_XLEN / 8;

    localparam int M_FETCH = 0;
    localparam int M_DATA  = 1;

    typedef struct packed {
        logic [MEM_XLEN-1:0]  addr;
        logic [MEM_BYTES-1:0] we;
        logic [MEM_XLEN-1:0]  wdata;
        logic                 lock;
    } mem_req_t;

    function automatic logic is_read(input logic [MEM_BYTES-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock.
//   clk, rstn : clock, asynchronous active-low reset
//   req[1:0]  : request per master (already gated by reset in the caller)
//   lock[1:0] : per-master "keep my grant next cycle" hint
//   gnt[1:0]  : one-hot grant, combinational; a grant is always a transfer
// A master that wins while holding lock keeps winning for as long as it keeps
// requesting, up to LOCK_MAX consecutive locked grants. Once the count hits
// LOCK_MAX, one cycle is arbitrated by plain round-robin and the count clears.
module rr_arb2 #(
    parameter int  LOCK_MAX = 4,
    localparam int CW       = $clog2(LOCK_MAX + 1)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

    logic          last_q, last_d;
    logic          own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked;
    logic          any_req;
    logic          win;

    always_comb begin
        locked  = (cnt_q != '0) && (cnt_q != LOCK_MAX_C) && req[own_q];
        any_req = |req;
        win     = 1'b0;
        last_d  = last_q;
        own_d   = own_q;
        cnt_d   = '0;

        if (locked) begin
            win = own_q;
        end else if (&req) begin
            win = ~last_q;
        end else begin
            win = req[1];
        end

        gnt = any_req ? (win ? 2'b10 : 2'b01) : 2'b00;

        if (any_req) begin
            last_d = win;
        end

        // The cycle after the streak limit is the forced round-robin cycle;
        // the count restarts from zero regardless of who wins it.
        if (cnt_q == LOCK_MAX_C) begin
            cnt_d = '0;
        end else if (any_req && lock[win]) begin
            own_d = win;
            cnt_d = (win == own_q && cnt_q != '0) ? cnt_q + CW'(1) : CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
            own_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            own_q  <= own_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous data-memory port between two masters.
//   m0_* : instruction-fetch / loader master;  m1_* : CPU load/store master
//   mN_req/we/addr/wdata/lock in, mN_gnt (comb), mN_rvalid/rdata (registered)
//   mem_r/mem_w/mem_addr/mem_din out to memory, mem_dout back (one cycle later)
// Handshake: a transfer happens at a rising edge where mN_req and mN_gnt are
// both high. The master holds we/addr/wdata/lock stable while req is high and
// gnt is low; gnt is combinational from req. Read data comes back on
// mN_rvalid/mN_rdata exactly one cycle after the read transfer, with no stall.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int  XLEN     = MEM_XLEN,
    parameter int  LOCK_MAX = 4,
    localparam int BYTES    = XLEN / 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             m0_req,
    input  logic [BYTES-1:0] m0_we,
    input  logic [XLEN-1:0]  m0_addr,
    input  logic [XLEN-1:0]  m0_wdata,
    input  logic             m0_lock,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [XLEN-1:0]  m0_rdata,
    input  logic             m1_req,
    input  logic [BYTES-1:0] m1_we,
    input  logic [XLEN-1:0]  m1_addr,
    input  logic [XLEN-1:0]  m1_wdata,
    input  logic             m1_lock,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [XLEN-1:0]  m1_rdata,
    output logic             mem_r,
    output logic [BYTES-1:0] mem_w,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_din,
    input  logic [XLEN-1:0]  mem_dout
);

    mem_req_t   req0, req1, sel;
    logic [1:0] req_v;
    logic [1:0] gnt;
    logic       xfer;
    logic       rsp_v_q, rsp_v_d;
    logic       rsp_own_q, rsp_own_d;

    // Requests are masked while reset is held so no grant or strobe leaks out.
    assign req_v = {m1_req, m0_req} & {2{rstn}};

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  (req_v),
        .lock ({m1_lock, m0_lock}),
        .gnt  (gnt)
    );

    always_comb begin
        req0 = '{addr: m0_addr, we: m0_we, wdata: m0_wdata, lock: m0_lock};
        req1 = '{addr: m1_addr, we: m1_we, wdata: m1_wdata, lock: m1_lock};
        sel  = gnt[M_DATA] ? req1 : req0;
        xfer = |gnt;

        m0_gnt   = gnt[M_FETCH];
        m1_gnt   = gnt[M_DATA];
        mem_r    = xfer && is_read(sel.we);
        mem_w    = xfer ? sel.we    : '0;
        mem_addr = xfer ? sel.addr  : '0;
        mem_din  = xfer ? sel.wdata : '0;

        rsp_v_d   = xfer && is_read(sel.we);
        rsp_own_d = gnt[M_DATA];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_v_q   <= 1'b0;
            rsp_own_q <= 1'b0;
        end else begin
            rsp_v_q   <= rsp_v_d;
            rsp_own_q <= rsp_own_d;
        end
    end

    always_comb begin
        m0_rvalid = rsp_v_q && !rsp_own_q;
        m1_rvalid = rsp_v_q &&  rsp_own_q;
        m0_rdata  = m0_rvalid ? mem_dout : '0;
        m1_rdata  = m1_rvalid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int XLEN     = 32;
    localparam int BYTES    = 4;
    localparam int LOCK_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             m0_req = 0, m1_req = 0, m0_lock = 0, m1_lock = 0;
    logic [BYTES-1:0] m0_we = 0, m1_we = 0;
    logic [XLEN-1:0]  m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic             m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_r;
    logic [XLEN-1:0]  m0_rdata, m1_rdata, mem_addr, mem_din, mem_dout;
    logic [BYTES-1:0] mem_w;

    mem_arbiter #(.XLEN(XLEN), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // ---------------- memory attached to the mem_* bus ----------------
    logic [7:0] ram [256];
    logic       ram_clr = 1'b1;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            mem_dout <= '0;
        end else begin
            if (mem_r) begin
                for (int i = 0; i < BYTES; i++)
                    mem_dout[i*8 +: 8] <= ram[8'(mem_addr[7:0] + 8'(i))];
            end else begin
                mem_dout <= $urandom;
            end
            for (int i = 0; i < BYTES; i++)
                if (mem_w[i]) ram[8'(mem_addr[7:0] + 8'(i))] <= mem_din[i*8 +: 8];
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: arbitration history plus a shadow of memory contents.
    int            mdl_last, mdl_owner, mdl_streak;
    logic [1:0]    mdl_gnt;
    logic [7:0]    model_mem [256];
    logic [XLEN:0] exp_q [$];   // {owner, read data} due one cycle later

    task automatic model_reset();
        mdl_last   = 1;
        mdl_owner  = 0;
        mdl_streak = 0;
        mdl_gnt    = 2'b00;
        exp_q.delete();
    endtask

    // One clock cycle: called after inputs are driven in the low clock phase.
    task automatic tick();
        int               win;
        logic [1:0]       rq, lk, exp_rv;
        logic [BYTES-1:0] w_we;
        logic [XLEN-1:0]  w_addr, w_din, rd, exp_rd0, exp_rd1;
        logic [XLEN:0]    rsp;
        #3;
        rq  = {m1_req, m0_req};
        lk  = {m1_lock, m0_lock};
        win = -1;
        if (rq != 2'b00) begin
            if (mdl_streak > 0 && mdl_streak < LOCK_MAX && rq[mdl_owner]) win = mdl_owner;
            else if (rq == 2'b11) win = 1 - mdl_last;
            else win = rq[1] ? 1 : 0;
        end
        mdl_gnt = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        w_we = '0; w_addr = '0; w_din = '0;
        if (win == 0) begin w_we = m0_we; w_addr = m0_addr; w_din = m0_wdata; end
        if (win == 1) begin w_we = m1_we; w_addr = m1_addr; w_din = m1_wdata; end

        chk("gnt", {m1_gnt, m0_gnt}, mdl_gnt);
        chk("mem_r", mem_r, (win >= 0) && (w_we == '0));
        chk("mem_w", mem_w, w_we);
        chk("mem_addr", mem_addr, w_addr);
        chk("mem_din", mem_din, w_din);

        exp_rv = 2'b00; exp_rd0 = '0; exp_rd1 = '0;
        if (exp_q.size() > 0) begin
            rsp = exp_q.pop_front();
            if (rsp[XLEN]) begin exp_rv = 2'b10; exp_rd1 = rsp[XLEN-1:0]; end
            else begin exp_rv = 2'b01; exp_rd0 = rsp[XLEN-1:0]; end
        end
        chk("rvalid", {m1_rvalid, m0_rvalid}, exp_rv);
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);

        if (win >= 0) begin
            if (w_we == '0) begin
                for (int i = 0; i < BYTES; i++)
                    rd[i*8 +: 8] = model_mem[8'(w_addr[7:0] + 8'(i))];
                exp_q.push_back({(win == 1), rd});
            end else begin
                for (int i = 0; i < BYTES; i++)
                    if (w_we[i]) model_mem[8'(w_addr[7:0] + 8'(i))] = w_din[i*8 +: 8];
            end
            mdl_last = win;
        end
        if (mdl_streak == LOCK_MAX) mdl_streak = 0;
        else if (win >= 0 && lk[win]) begin
            mdl_streak = (win == mdl_owner) ? mdl_streak + 1 : 1;
            mdl_owner  = win;
        end else mdl_streak = 0;

        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic             r0, r1, l0, l1;
        logic [BYTES-1:0] we0, we1;
        logic [XLEN-1:0]  a0, a1, d0, d1;
        logic [1:0]       exp_gnt;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic r1, input logic l0,
                                input logic l1, input logic [1:0] g);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
        v.we0 = '0; v.we1 = '0;
        v.a0 = 32'h20; v.a1 = 32'h24; v.d0 = '0; v.d1 = '0;
        v.exp_gnt = g;
        return v;
    endfunction

    task automatic apply_row(input vec_t v, input int idx);
        m0_req = v.r0; m0_lock = v.l0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_lock = v.l1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
        #1;
        chk($sformatf("tbl_gnt[%0d]", idx), {m1_gnt, m0_gnt}, v.exp_gnt);
        tick();
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t t2 [4];
    vec_t t3 [6];
    logic pend0, pend1;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_reset();
        do_reset();
        ram_clr = 1'b0;

        // Reset state of the outputs with no requests.
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);

        // Idle bus drives zeros.
        #1;
        chk("idle_mem_r", mem_r, 1'b0);
        chk("idle_mem_w", mem_w, 4'b0000);
        chk("idle_mem_addr", mem_addr, 32'h0);
        tick();

        // m1 alone: byte write then read back.
        m1_req = 1; m1_we = 4'b0001; m1_addr = 32'h0; m1_wdata = 32'h84;
        tick();
        m1_we = 4'b0000;
        tick();
        idle_inputs();
        chk("t1_m1_rvalid", m1_rvalid, 1'b1);
        chk("t1_m1_rdata", m1_rdata[7:0], 8'h84);
        tick();

        // Both read, no lock: strict alternation starting with m0.
        do_reset();
        t2[0] = mk(1, 1, 0, 0, 2'b01);
        t2[1] = mk(1, 1, 0, 0, 2'b10);
        t2[2] = mk(1, 1, 0, 0, 2'b01);
        t2[3] = mk(1, 1, 0, 0, 2'b10);
        for (int i = 0; i < 4; i++) apply_row(t2[i], i);
        idle_inputs();
        tick();

        // m1 holds lock: four consecutive grants, then m0 gets one.
        do_reset();
        t3[0] = mk(0, 1, 0, 1, 2'b10);
        t3[1] = mk(1, 1, 0, 1, 2'b10);
        t3[2] = mk(1, 1, 0, 1, 2'b10);
        t3[3] = mk(1, 1, 0, 1, 2'b10);
        t3[4] = mk(1, 1, 0, 1, 2'b01);
        t3[5] = mk(0, 1, 0, 1, 2'b10);
        for (int i = 0; i < 6; i++) apply_row(t3[i], 10 + i);
        idle_inputs();
        tick();

        // Reset in the cycle after an m0 read grant drops the response.
        do_reset();
        m0_req = 1; m0_addr = 32'h10;
        tick();
        rstn = 1'b0;
        m1_req = 1; m1_addr = 32'h14;
        #1;
        chk("t4_rvalid_in_rst", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("t4_gnt_in_rst", {m1_gnt, m0_gnt}, 2'b00);
        chk("t4_mem_r_in_rst", mem_r, 1'b0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("t4_first_tie", {m1_gnt, m0_gnt}, 2'b01);
        tick();
        m0_req = 0;
        tick();
        idle_inputs();
        tick();

        // m0 upper-half write.
        m0_req = 1; m0_we = 4'b1100; m0_addr = 32'h4; m0_wdata = 32'hAABB_CCDD;
        #1;
        chk("t5_mem_w", mem_w, 4'b1100);
        chk("t5_mem_r", mem_r, 1'b0);
        tick();
        idle_inputs();
        chk("t5_byte6", ram[6], 8'hBB);
        chk("t5_byte7", ram[7], 8'hAA);
        chk("t5_byte5", ram[5], 8'h00);
        chk("t5_no_rvalid", m0_rvalid, 1'b0);
        tick();

        // Randomized traffic; a master holds its request until granted.
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pend0 && $urandom_range(0, 9) < 8) begin
                pend0 = 1;
                m0_we = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
                m0_addr = 32'($urandom_range(0, 63));
                m0_wdata = $urandom;
                m0_lock = ($urandom_range(0, 1) == 1);
            end
            if (!pend1 && $urandom_range(0, 9) < 8) begin
                pend1 = 1;
                m1_we = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
                m1_addr = 32'($urandom_range(0, 63));
                m1_wdata = $urandom;
                m1_lock = ($urandom_range(0, 2) != 0);
            end
            m0_req = pend0;
            m1_req = pend1;
            tick();
            if (mdl_gnt[0]) pend0 = 0;
            if (mdl_gnt[1]) pend1 = 0;
        end
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
